// File: rtl/branch_resolve_unit_if.sv
// Issue-side and redirect-side bundle for branch_resolve_unit.
// BRU_MISPREDICT_EN adds pred_taken_i / mispredict_o.
interface branch_resolve_unit_if;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [2:0]  funct3_i;
   logic [31:0] pc_i;
   logic [31:0] imm_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic        taken_o;
   logic [31:0] next_pc_o;
   logic        illegal_o;
`ifdef BRU_MISPREDICT_EN
   logic        pred_taken_i;
   logic        mispredict_o;

   modport master (
      output in_valid_i, rs1_i, rs2_i, funct3_i, pc_i, imm_i, flush_i, out_ready_i, pred_taken_i,
      input  in_ready_o, out_valid_o, taken_o, next_pc_o, illegal_o, mispredict_o
   );
   modport slave (
      input  in_valid_i, rs1_i, rs2_i, funct3_i, pc_i, imm_i, flush_i, out_ready_i, pred_taken_i,
      output in_ready_o, out_valid_o, taken_o, next_pc_o, illegal_o, mispredict_o
   );
`else
   modport master (
      output in_valid_i, rs1_i, rs2_i, funct3_i, pc_i, imm_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, taken_o, next_pc_o, illegal_o
   );
   modport slave (
      input  in_valid_i, rs1_i, rs2_i, funct3_i, pc_i, imm_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, taken_o, next_pc_o, illegal_o
   );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: S1 holds operands feeding the comparator, S2 holds the decision.
// Optional macro BRU_MISPREDICT_EN adds predicted-direction tracking and mispredict_o.
module branch_resolve_unit (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   branch_resolve_unit_if.slave  bus
);
   logic        s1_valid_q, s1_valid_d;
   logic [31:0] s1_rs1_q, s1_rs1_d;
   logic [31:0] s1_rs2_q, s1_rs2_d;
   logic [2:0]  s1_funct3_q, s1_funct3_d;
   logic [31:0] s1_pc_q, s1_pc_d;
   logic [31:0] s1_imm_q, s1_imm_d;
   logic        s2_valid_q, s2_valid_d;
   logic        s2_taken_q, s2_taken_d;
   logic [31:0] s2_next_pc_q, s2_next_pc_d;
   logic        s2_illegal_q, s2_illegal_d;

   logic        s2_free, s1_adv, in_ready, accept;
   logic        cmp_eq, cmp_lt_u, cmp_lt_s;
   logic        taken, illegal;
   logic [31:0] next_pc;

   always_comb begin
      s2_free  = !s2_valid_q || bus.out_ready_i;
      s1_adv   = s1_valid_q && s2_free;
      in_ready = (!s1_valid_q || s2_free) && !bus.flush_i;
      accept   = bus.in_valid_i && in_ready;
   end

   // Unsigned magnitude compare; signed lt is derived by sign-bit correction.
   always_comb begin
      cmp_eq   = (s1_rs1_q == s1_rs2_q);
      cmp_lt_u = (s1_rs1_q < s1_rs2_q);
      cmp_lt_s = (s1_rs1_q[31] != s1_rs2_q[31]) ? s1_rs1_q[31] : cmp_lt_u;
      taken    = 1'b0;
      illegal  = 1'b0;
      case (s1_funct3_q)
         3'b000:  taken = cmp_eq;
         3'b001:  taken = !cmp_eq;
         3'b100:  taken = cmp_lt_s;
         3'b101:  taken = !cmp_lt_s;
         3'b110:  taken = cmp_lt_u;
         3'b111:  taken = !cmp_lt_u;
         default: illegal = 1'b1;
      endcase
      next_pc = taken ? (s1_pc_q + s1_imm_q) : (s1_pc_q + 32'd4);
   end

   always_comb begin
      s1_rs1_d     = accept ? bus.rs1_i    : s1_rs1_q;
      s1_rs2_d     = accept ? bus.rs2_i    : s1_rs2_q;
      s1_funct3_d  = accept ? bus.funct3_i : s1_funct3_q;
      s1_pc_d      = accept ? bus.pc_i     : s1_pc_q;
      s1_imm_d     = accept ? bus.imm_i    : s1_imm_q;
      s2_taken_d   = s1_adv ? taken        : s2_taken_q;
      s2_next_pc_d = s1_adv ? next_pc      : s2_next_pc_q;
      s2_illegal_d = s1_adv ? illegal      : s2_illegal_q;
      // Flush kills both stages even if a result is being handed off this cycle.
      if (bus.flush_i)  s1_valid_d = 1'b0;
      else if (accept)  s1_valid_d = 1'b1;
      else if (s1_adv)  s1_valid_d = 1'b0;
      else              s1_valid_d = s1_valid_q;
      if (bus.flush_i)          s2_valid_d = 1'b0;
      else if (s1_adv)          s2_valid_d = 1'b1;
      else if (bus.out_ready_i) s2_valid_d = 1'b0;
      else                      s2_valid_d = s2_valid_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q   <= 1'b0;
         s1_rs1_q     <= '0;
         s1_rs2_q     <= '0;
         s1_funct3_q  <= '0;
         s1_pc_q      <= '0;
         s1_imm_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_taken_q   <= 1'b0;
         s2_next_pc_q <= '0;
         s2_illegal_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_rs1_q     <= s1_rs1_d;
         s1_rs2_q     <= s1_rs2_d;
         s1_funct3_q  <= s1_funct3_d;
         s1_pc_q      <= s1_pc_d;
         s1_imm_q     <= s1_imm_d;
         s2_valid_q   <= s2_valid_d;
         s2_taken_q   <= s2_taken_d;
         s2_next_pc_q <= s2_next_pc_d;
         s2_illegal_q <= s2_illegal_d;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = s2_valid_q;
   assign bus.taken_o     = s2_taken_q;
   assign bus.next_pc_o   = s2_next_pc_q;
   assign bus.illegal_o   = s2_illegal_q;

`ifdef BRU_MISPREDICT_EN
   logic s1_pred_q, s1_pred_d;
   logic s2_pred_q, s2_pred_d;

   always_comb begin
      s1_pred_d = accept ? bus.pred_taken_i : s1_pred_q;
      s2_pred_d = s1_adv ? s1_pred_q        : s2_pred_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_pred_q <= 1'b0;
         s2_pred_q <= 1'b0;
      end else begin
         s1_pred_q <= s1_pred_d;
         s2_pred_q <= s2_pred_d;
      end
   end

   assign bus.mispredict_o = s2_valid_q && (s2_taken_q != s2_pred_q);
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus stream, backpressure, flush and reset sequences.
module tb_branch_resolve_unit;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   branch_resolve_unit_if bus ();

   branch_resolve_unit dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [2:0]  f3;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        pred;
      logic        taken;
      logic [31:0] npc;
      logic        ill;
   } vec_t;

   vec_t vecs [13];

   logic        mon_en = 1'b0;
   logic [31:0] mon_pc [$];
   int          mon_cyc [$];

   always @(negedge clk) begin
      if (mon_en && bus.out_valid_o && bus.out_ready_i && !bus.flush_i) begin
         mon_pc.push_back(bus.next_pc_o);
         mon_cyc.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
      bus.in_valid_i = 1'b1;
      bus.rs1_i      = rs1;
      bus.rs2_i      = rs2;
      bus.funct3_i   = f3;
      bus.pc_i       = pc;
      bus.imm_i      = imm;
`ifdef BRU_MISPREDICT_EN
      bus.pred_taken_i = pred;
`else
      if (pred) bus.imm_i = imm;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   n;
      v = vecs[idx];
      drive(v.rs1, v.rs2, v.f3, v.pc, v.imm, v.pred);
      check($sformatf("vec%0d in_ready", idx), bus.in_ready_o, 1'b1);
      tick();
      bus.in_valid_i = 1'b0;
      n = 1;
      while (!bus.out_valid_o && n < 10) begin
         tick();
         n++;
      end
      check($sformatf("vec%0d latency", idx), n, 2);
      check($sformatf("vec%0d taken", idx), bus.taken_o, v.taken);
      check($sformatf("vec%0d next_pc", idx), bus.next_pc_o, v.npc);
      check($sformatf("vec%0d illegal", idx), bus.illegal_o, v.ill);
`ifdef BRU_MISPREDICT_EN
      check($sformatf("vec%0d mispredict", idx), bus.mispredict_o, v.taken != v.pred);
`endif
      tick();
      check($sformatf("vec%0d drained", idx), bus.out_valid_o, 1'b0);
   endtask

   initial begin
      logic ok;
      vecs[0]  = '{32'h0000_1234, 32'h0000_1234, 3'b000, 32'h0000_0100, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0120, 1'b0};
      vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 32'h0000_0200, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0240, 1'b0};
      vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0200, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0204, 1'b0};
      vecs[3]  = '{32'h0000_0005, 32'h0000_0006, 3'b001, 32'h0000_0300, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h0000_02F0, 1'b0};
      vecs[4]  = '{32'h0000_0005, 32'h0000_0006, 3'b001, 32'h0000_0300, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h0000_02F0, 1'b0};
      vecs[5]  = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b101, 32'h0000_0400, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0408, 1'b0};
      vecs[6]  = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b111, 32'h0000_0400, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0404, 1'b0};
      vecs[7]  = '{32'h0000_0003, 32'h0000_0009, 3'b010, 32'h0000_0500, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0504, 1'b1};
      vecs[8]  = '{32'h0000_0007, 32'h0000_0007, 3'b011, 32'h0000_0500, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0504, 1'b1};
      vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 3'b000, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0004, 1'b0};
      vecs[10] = '{32'h0000_0007, 32'h0000_0007, 3'b001, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
      vecs[11] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b100, 32'h0000_0600, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0610, 1'b0};
      vecs[12] = '{32'h0000_0001, 32'h0000_0002, 3'b000, 32'h0000_0700, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0704, 1'b0};

      rst_n = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.rs1_i       = '0;
      bus.rs2_i       = '0;
      bus.funct3_i    = '0;
      bus.pc_i        = '0;
      bus.imm_i       = '0;
      bus.flush_i     = 1'b0;
      bus.out_ready_i = 1'b1;
`ifdef BRU_MISPREDICT_EN
      bus.pred_taken_i = 1'b0;
`endif
      #22 rst_n = 1'b1;
      #1;
      check("rst out_valid", bus.out_valid_o, 1'b0);
      check("rst taken", bus.taken_o, 1'b0);
      check("rst next_pc", bus.next_pc_o, 32'h0);
      check("rst illegal", bus.illegal_o, 1'b0);
      check("rst in_ready", bus.in_ready_o, 1'b1);
`ifdef BRU_MISPREDICT_EN
      check("rst mispredict", bus.mispredict_o, 1'b0);
`endif
      tick();

      for (int i = 0; i < 13; i++) run_vec(i);

      // Back-to-back stream with the sink always ready.
      mon_pc.delete();
      mon_cyc.delete();
      mon_en = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive((i % 2 == 1) ? i : 0, 32'h0, 3'b000, 32'h1000 + i * 16, 32'h100, 1'b0);
         if (!bus.in_ready_o) ok = 1'b0;
         tick();
      end
      bus.in_valid_i = 1'b0;
      check("stream in_ready held", ok, 1'b1);
      repeat (4) tick();
      mon_en = 1'b0;
      check("stream count", mon_pc.size(), 8);
      if (mon_pc.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("stream%0d next_pc", i), mon_pc[i],
                  (i % 2 == 1) ? (32'h1000 + i * 16 + 4) : (32'h1000 + i * 16 + 32'h100));
            check($sformatf("stream%0d cycle", i), mon_cyc[i] - mon_cyc[0], i);
         end
      end

      // Backpressure: fill both stages, hold the sink off for 3 cycles.
      bus.out_ready_i = 1'b0;
      drive(32'h1, 32'h1, 3'b000, 32'h2000, 32'h40, 1'b0);
      tick();
      drive(32'h1, 32'h2, 3'b000, 32'h3000, 32'h40, 1'b0);
      tick();
      drive(32'h5, 32'h5, 3'b000, 32'h4000, 32'h80, 1'b0);
      check("bp in_ready full", bus.in_ready_o, 1'b0);
      check("bp out_valid", bus.out_valid_o, 1'b1);
      check("bp next_pc A", bus.next_pc_o, 32'h2040);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.in_ready_o || !bus.out_valid_o || bus.next_pc_o !== 32'h2040 || !bus.taken_o) ok = 1'b0;
      end
      check("bp stable 3 cycles", ok, 1'b1);
      bus.out_ready_i = 1'b1;
      #1;
      check("bp in_ready on release", bus.in_ready_o, 1'b1);
      tick();
      bus.in_valid_i = 1'b0;
      check("bp next_pc B", bus.next_pc_o, 32'h3004);
      check("bp out_valid B", bus.out_valid_o, 1'b1);
      tick();
      check("bp next_pc C", bus.next_pc_o, 32'h4080);
      tick();
      check("bp drained", bus.out_valid_o, 1'b0);

      // Flush with both stages full and a pending input.
      bus.out_ready_i = 1'b0;
      drive(32'h1, 32'h1, 3'b000, 32'h5000, 32'h10, 1'b0);
      tick();
      drive(32'h1, 32'h1, 3'b000, 32'h6000, 32'h10, 1'b0);
      tick();
      drive(32'h1, 32'h1, 3'b000, 32'h7000, 32'h10, 1'b0);
      bus.flush_i     = 1'b1;
      bus.out_ready_i = 1'b1;
      #1;
      check("flush in_ready", bus.in_ready_o, 1'b0);
      tick();
      bus.flush_i = 1'b0;
      drive(32'h1, 32'h1, 3'b000, 32'h8000, 32'h10, 1'b0);
      check("flush out_valid next", bus.out_valid_o, 1'b0);
      tick();
      bus.in_valid_i = 1'b0;
      check("flush post op not yet", bus.out_valid_o, 1'b0);
      tick();
      check("flush post op valid", bus.out_valid_o, 1'b1);
      check("flush post op next_pc", bus.next_pc_o, 32'h8010);
      tick();
      check("flush drained", bus.out_valid_o, 1'b0);

      // Reset while an op is in flight.
      drive(32'h1, 32'h1, 3'b000, 32'h9000, 32'h10, 1'b0);
      tick();
      bus.in_valid_i = 1'b0;
      rst_n = 1'b0;
      #2;
      check("midrst out_valid", bus.out_valid_o, 1'b0);
      tick();
      #2 rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.out_valid_o) ok = 1'b0;
      end
      check("midrst no output", ok, 1'b1);
      check("midrst in_ready", bus.in_ready_o, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Two-stage pipelined branch resolution unit for the integer core. Accepts a conditional-branch micro-op (two register operands, funct3, PC, B-immediate) from the execute issue stage through a valid/ready handshake. Stage 1 registers the operands and drives the 32-bit unsigned magnitude comparator. Stage 2 consumes the comparator's equal/less/greater results, applies signed correction, and registers the taken decision with the next-PC toward fetch redirect.

## Interface
- XLEN, 32, operand/PC width; only 32 is supported.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  upstream micro-op valid.
- in_ready_o  output  1  unit can accept this cycle.
- rs1_i, rs2_i  input  32  branch operands.
- funct3_i  input  3  branch condition code.
- pc_i  input  32  branch PC.
- imm_i  input  32  sign-extended B-immediate.
- flush_i  input  1  kill all in-flight micro-ops.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts result.
- taken_o  output  1  branch taken.
- next_pc_o  output  32  pc+imm if taken, else pc+4.
- illegal_o  output  1  funct3 was 010 or 011.

## Operation
- Stage 1 (S1) registers rs1, rs2, funct3, pc, and imm on handshake (in_valid_i && in_ready_o). Comparator inputs are the S1 operand registers.
- Stage 2 (S2) captures taken, next_pc, and illegal when S1 advances.
- Signed less-than: if rs1[31]≠rs2[31], then lt = rs1[31]; else lt = unsigned a_less_b. Signed ge = !lt.
- Condition codes:
  - 000 BEQ: eq.
  - 001 BNE: !eq.
  - 100 BLT: signed lt.
  - 101 BGE: !signed lt.
  - 110 BLTU: a_less_b.
  - 111 BGEU: !a_less_b.
  - 010/011: taken=0, illegal=1.
- next_pc: taken → pc+imm; else pc+4. Both sums are 32-bit with wrap-around and no overflow flag.
- Advance rules:
  - s2_free = !s2_valid || out_ready_i.
  - S1 advances when s1_valid && s2_free.
  - in_ready_o = (!s1_valid || s2_free) && !flush_i.
- Flush: s1_valid and s2_valid go to 0 at the next edge. flush_i overrides a simultaneous input handshake (nothing is accepted) and a simultaneous output handshake (the result is considered consumed/killed). Data registers are not cleared.
- Output holds stable while out_valid_o && !out_ready_i.

## Timing
- Reset (async assert, sync release):
  - s1_valid=0, s2_valid=0.
  - out_valid_o=0, taken_o=0, next_pc_o=0, illegal_o=0.
  - in_ready_o=1 (combinational, after reset).
  - With BRU_MISPREDICT_EN: mispredict_o=0.
- Latency: accept at edge N → out_valid_o high after edge N+1, i.e. the result is presented in cycle N+2 when the pipe is unstalled.
- Throughput: 1 micro-op/cycle with out_ready_i held high.
- Backpressure: when S2 is full and out_ready_i=0, S1 holds. When S1 is also full, in_ready_o=0. Maximum occupancy is 2.
- Reset mid-operation: all in-flight micro-ops are lost. No output appears for them after release.
- The comparator path and condition select are combinational in the S1→S2 register-to-register path.

## Configuration
- BRU_MISPREDICT_EN defined:
  - Adds input pred_taken_i (captured with the operands in S1).
  - Adds output mispredict_o = S2 taken ≠ S2 pred_taken, valid only while out_valid_o is high and 0 otherwise.
- Undefined: these ports and their registers do not exist. Downstream treats every taken branch as a redirect.

## Test plan
- Reset then single BEQ with rs1=rs2=0x0000_1234, pc=0x100, imm=0x20 → after 2 cycles out_valid_o=1, taken_o=1, next_pc_o=0x120.
- BLT with rs1=0xFFFF_FFFF (−1), rs2=1 → taken_o=1. The same operands with BLTU → taken_o=0, next_pc_o=pc+4.
- Back-to-back stream of 8 ops with out_ready_i=1 → 8 results on 8 consecutive cycles, in order. Then hold out_ready_i=0 for 3 cycles → in_ready_o=0 after 2 ops are held, and the output is stable.
- flush_i asserted with both stages full and in_valid_i=1 → no handshake that cycle. out_valid_o=0 on the next cycle, and the next accepted op emerges 2 cycles later.
- funct3=010 → illegal_o=1, taken_o=0. Wrap case pc=0xFFFF_FFFC with taken imm=8 → next_pc_o=0x0000_0004.
- With BRU_MISPREDICT_EN: BNE with rs1≠rs2 and pred_taken_i=0 → mispredict_o=1. Same case with pred_taken_i=1 → mispredict_o=0. Without the macro, the bench compiles without those ports.
